// File: rtl/text_pkg.sv
// text_pkg: shared constants and state encoding for the LCD text buffer
package text_pkg;
  localparam int COLS_DEFAULT = 16;
  localparam int ROWS_DEFAULT = 2;
  localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;
  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/text_ram.sv
// text_ram: single-port character RAM with power-up pattern and registered, holding read
module text_ram #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int INIT_BASE = 48
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  function automatic logic [DEPTH-1:0][7:0] init_mem();
    logic [DEPTH-1:0][7:0] m;
    for (int i = 0; i < DEPTH; i++) m[i] = 8'(INIT_BASE + i);
    return m;
  endfunction
  logic [DEPTH-1:0][7:0] mem = init_mem();
  always_ff @(posedge i_clk) begin
    if (we) mem[addr] <= wdata;
    if (!i_rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: arbitrates the text RAM between scan-out reads, a cursor-driven char writer and a clear sweep
module text_buffer_ctrl import text_pkg::*; #(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT,
  parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEFAULT,
  parameter int INIT_BASE = 48,
  localparam int DEPTH = ROWS * COLS,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_rd_valid,
  input  logic          i_char_valid,
  input  logic [7:0]    i_char_data,
  output logic          o_char_ready,
  input  logic          i_cursor_set,
  input  logic [AW-1:0] i_cursor_addr,
  output logic [AW-1:0] o_cursor,
  input  logic          i_clear,
  output logic          o_busy
);
  state_t state, state_nx;
  logic rd_oob, oob_q, ram_we, sweep_last, char_fire;
  logic [7:0] ram_q;
  logic [AW-1:0] idx, cursor_inc, cursor_nl, ram_addr;
  int nl_row;
  assign rd_oob = int'(i_rd_addr) >= DEPTH;
  assign o_busy = state == CLEAR;
  assign o_char_ready = state == IDLE && !i_rd_en && !i_cursor_set && !i_clear;
  assign char_fire = i_char_valid && o_char_ready;
  assign sweep_last = state == CLEAR && !i_rd_en && int'(idx) == DEPTH - 1;
  assign ram_we = i_rst_n && ((state == CLEAR && !i_rd_en) || (char_fire && i_char_data != CHAR_NEWLINE));
  assign ram_addr = i_rd_en ? i_rd_addr : state == CLEAR ? idx : o_cursor;
  assign o_rd_data = oob_q ? FILL_CHAR : ram_q;
  always_comb begin
    nl_row = (int'(o_cursor) / COLS + 1) * COLS;
    cursor_nl = nl_row >= DEPTH ? '0 : AW'(nl_row);
    cursor_inc = int'(o_cursor) == DEPTH - 1 ? '0 : o_cursor + 1'b1;
    state_nx = state == IDLE ? (i_clear ? CLEAR : IDLE) : (sweep_last ? IDLE : CLEAR);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_cursor <= '0;
      idx <= '0;
      o_rd_valid <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      state <= state_nx;
      o_rd_valid <= i_rd_en;
      if (i_rd_en) oob_q <= rd_oob;
      idx <= sweep_last ? '0 : (state == CLEAR && !i_rd_en) ? idx + 1'b1 : idx;
      if (sweep_last) o_cursor <= '0;
      else if (state == IDLE && !i_clear && i_cursor_set) o_cursor <= int'(i_cursor_addr) >= DEPTH ? '0 : i_cursor_addr;
      else if (char_fire) o_cursor <= i_char_data == CHAR_NEWLINE ? cursor_nl : cursor_inc;
    end
  end
  text_ram #(.DEPTH(DEPTH), .AW(AW), .INIT_BASE(INIT_BASE)) u_ram (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .we(ram_we),
    .re(i_rd_en && !rd_oob),
    .addr(ram_addr),
    .wdata(o_busy ? FILL_CHAR : i_char_data),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: directed table and corner-case sequences for text_buffer_ctrl
module tb_text_buffer_ctrl;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_rd_en = 1'b0, i_char_valid = 1'b0, i_cursor_set = 1'b0, i_clear = 1'b0;
  logic [4:0] i_rd_addr = '0, i_cursor_addr = '0, o_cursor;
  logic [7:0] i_char_data = '0, o_rd_data;
  logic o_rd_valid, o_char_ready, o_busy;
  int checks = 0, errors = 0;
  typedef struct {
    logic rd_en; logic [4:0] rd_addr; logic cv; logic [7:0] cd; logic cs; logic [4:0] ca;
    logic rv; logic [7:0] rdata; logic [4:0] cur; logic rdy;
  } vec_t;
  vec_t tbl[18];
  text_buffer_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_char_valid(i_char_valid),
    .i_char_data(i_char_data), .o_char_ready(o_char_ready), .i_cursor_set(i_cursor_set),
    .i_cursor_addr(i_cursor_addr), .o_cursor(o_cursor), .i_clear(i_clear), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic idle();
    i_rd_en = 0; i_char_valid = 0; i_cursor_set = 0; i_clear = 0;
  endtask
  task automatic rd(input int a, input logic [7:0] exp, input string nm);
    idle(); i_rd_en = 1; i_rd_addr = 5'(a);
    tick();
    chk(nm, o_rd_data, exp);
    chk({nm, "_valid"}, o_rd_valid, 1);
    idle();
  endtask
  task automatic put(input logic [7:0] c);
    idle(); i_char_valid = 1; i_char_data = c;
    tick();
    idle();
  endtask
  task automatic setc(input int a);
    idle(); i_cursor_set = 1; i_cursor_addr = 5'(a);
    tick();
    idle();
  endtask
  initial begin
    int busy_cnt;
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 1, 8'h30, 0, 0};
    tbl[1]  = '{1, 5, 0, 8'h00, 0, 0, 1, 8'h35, 0, 0};
    tbl[2]  = '{1, 31, 0, 8'h00, 0, 0, 1, 8'h4F, 0, 0};
    tbl[3]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h4F, 0, 1};
    tbl[4]  = '{0, 0, 1, 8'h41, 1, 15, 0, 8'h4F, 15, 0};
    tbl[5]  = '{0, 0, 1, 8'h41, 0, 0, 0, 8'h4F, 16, 1};
    tbl[6]  = '{0, 0, 1, 8'h42, 0, 0, 0, 8'h4F, 17, 1};
    tbl[7]  = '{1, 15, 1, 8'h5A, 0, 0, 1, 8'h41, 17, 0};
    tbl[8]  = '{1, 16, 0, 8'h00, 0, 0, 1, 8'h42, 17, 0};
    tbl[9]  = '{0, 0, 0, 8'h00, 1, 3, 0, 8'h42, 3, 0};
    tbl[10] = '{0, 0, 1, 8'h0A, 0, 0, 0, 8'h42, 16, 1};
    tbl[11] = '{1, 3, 0, 8'h00, 0, 0, 1, 8'h33, 16, 0};
    tbl[12] = '{0, 0, 0, 8'h00, 1, 20, 0, 8'h33, 20, 0};
    tbl[13] = '{0, 0, 1, 8'h0A, 0, 0, 0, 8'h33, 0, 1};
    tbl[14] = '{1, 20, 0, 8'h00, 0, 0, 1, 8'h44, 0, 0};
    tbl[15] = '{0, 0, 0, 8'h00, 1, 31, 0, 8'h44, 31, 0};
    tbl[16] = '{0, 0, 1, 8'h43, 0, 0, 0, 8'h44, 0, 1};
    tbl[17] = '{1, 31, 0, 8'h00, 0, 0, 1, 8'h43, 0, 0};
    tick();
    tick();
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_cursor", o_cursor, 0);
    chk("rst_busy", o_busy, 0);
    i_rst_n = 1;
    for (int i = 0; i < 18; i++) begin
      i_rd_en = tbl[i].rd_en; i_rd_addr = tbl[i].rd_addr; i_char_valid = tbl[i].cv;
      i_char_data = tbl[i].cd; i_cursor_set = tbl[i].cs; i_cursor_addr = tbl[i].ca;
      #1;
      chk($sformatf("v%0d_ready", i), o_char_ready, tbl[i].rdy);
      tick();
      chk($sformatf("v%0d_rd_valid", i), o_rd_valid, tbl[i].rv);
      chk($sformatf("v%0d_rd_data", i), o_rd_data, tbl[i].rdata);
      chk($sformatf("v%0d_cursor", i), o_cursor, tbl[i].cur);
      chk($sformatf("v%0d_busy", i), o_busy, 0);
    end
    idle();
    setc(5);
    for (int k = 0; k < 4; k++) begin
      i_rd_en = 1; i_rd_addr = 5'(k); i_char_valid = 1; i_char_data = 8'h51;
      #1;
      chk($sformatf("hold%0d_ready", k), o_char_ready, 0);
      tick();
      chk($sformatf("hold%0d_data", k), o_rd_data, 8'h30 + 8'(k));
      chk($sformatf("hold%0d_cursor", k), o_cursor, 5);
    end
    i_rd_en = 0;
    #1;
    chk("hold_release_ready", o_char_ready, 1);
    tick();
    chk("hold_release_cursor", o_cursor, 6);
    chk("hold_release_valid", o_rd_valid, 0);
    idle();
    rd(5, 8'h51, "hold_cell5");
    setc(31);
    for (int k = 0; k < 31; k++) put(8'h60 + 8'(k));
    chk("wrap_cursor", o_cursor, 30);
    rd(31, 8'h60, "wrap_cell31");
    rd(0, 8'h61, "wrap_cell0");
    rd(29, 8'h7E, "wrap_cell29");
    rd(30, 8'h4E, "wrap_cell30");
    setc(9);
    i_clear = 1;
    tick();
    idle();
    chk("clr_busy_start", o_busy, 1);
    busy_cnt = 1;
    for (int c = 0; c < 100; c++) begin
      i_rd_en = (c % 2 == 0); i_rd_addr = 5'd0; i_clear = (c == 11); i_char_valid = 1; i_char_data = 8'h55;
      #1;
      if (c == 21) chk("clr_ready", o_char_ready, 0);
      tick();
      if (!o_busy) break;
      busy_cnt++;
    end
    idle();
    chk("clr_busy_cycles", busy_cnt, 64);
    chk("clr_cursor", o_cursor, 0);
    for (int a = 0; a < 32; a++) rd(a, 8'h20, $sformatf("clr_cell%0d", a));
    tick();
    chk("clr_idle_busy", o_busy, 0);
    setc(0);
    for (int k = 0; k < 32; k++) put(8'h61 + 8'(k));
    chk("fill_cursor", o_cursor, 0);
    setc(7);
    chk("fill_cursor7", o_cursor, 7);
    i_clear = 1;
    tick();
    idle();
    for (int k = 0; k < 10; k++) tick();
    i_rst_n = 0;
    tick();
    chk("rstclr_busy", o_busy, 0);
    chk("rstclr_cursor", o_cursor, 0);
    chk("rstclr_rd_valid", o_rd_valid, 0);
    chk("rstclr_rd_data", o_rd_data, 0);
    i_rst_n = 1;
    for (int a = 0; a < 32; a++) rd(a, a < 10 ? 8'h20 : 8'h61 + 8'(a), $sformatf("rstclr_cell%0d", a));
    setc(31);
    chk("set31_cursor", o_cursor, 31);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
